// File: rtl/jtag_dma_chain_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_dma_chain_if
// Brief    : Ping-pong buffer and DMA command bundle between the JTAG chain
//            front end (master) and the buffer/DMA side (slave).
// Revision : 1.0
// ============================================================================
interface jtag_dma_chain_if #(
  parameter int DATA_W    = 32,
  parameter int PP_ADDR_W = 9,
  parameter int BURST_W   = 8
);
  localparam int c_BE_W = DATA_W / 8;

  logic [PP_ADDR_W-1:0] pp_address;
  logic                 pp_we;
  logic [DATA_W-1:0]    pp_din;
  logic [DATA_W-1:0]    pp_dout;
  logic                 pp_switch;
  logic                 switch_ready;
  logic [31:0]          dma_address;
  logic [c_BE_W-1:0]    dma_byte_enable;
  logic [BURST_W-1:0]   dma_burst_size;
  logic                 dma_write_start;
  logic                 dma_read_start;
  logic                 dma_error;

  modport master (
    output pp_address, pp_we, pp_din, pp_switch,
    output dma_address, dma_byte_enable, dma_burst_size,
    output dma_write_start, dma_read_start,
    input  pp_dout, switch_ready, dma_error
  );

  modport slave (
    input  pp_address, pp_we, pp_din, pp_switch,
    input  dma_address, dma_byte_enable, dma_burst_size,
    input  dma_write_start, dma_read_start,
    output pp_dout, switch_ready, dma_error
  );
endinterface
`default_nettype wire

// File: rtl/jtag_dma_chain.sv
`default_nettype none
// ============================================================================
// Module   : jtag_dma_chain
// Brief    : JTAG user-chain front end turning opcode-tagged DR frames into
//            ping-pong buffer writes/reads and DMA burst launches.
// Revision : 1.0
// ============================================================================
module jtag_dma_chain #(
  parameter int DATA_W    = 32,
  parameter int OP_W      = 4,
  parameter int PP_ADDR_W = 9,
  parameter int BURST_W   = 8
) (
  input  wire              JTCK,
  input  wire              JRSTN,
  input  wire              JTDI,
  input  wire              JSHIFT,
  input  wire              JUPDATE,
  input  wire              JCE,
  output logic             JTDO,
  output logic [7:0]       status_out,
  jtag_dma_chain_if.master bus
);
  localparam int c_BE_W = DATA_W / 8;
  localparam int c_SR_W = DATA_W + OP_W;

  localparam logic [OP_W-1:0] c_OP_ADDR  = OP_W'(4'h1);
  localparam logic [OP_W-1:0] c_OP_BE    = OP_W'(4'h2);
  localparam logic [OP_W-1:0] c_OP_SIZE  = OP_W'(4'h3);
  localparam logic [OP_W-1:0] c_OP_WDATA = OP_W'(4'h8);
  localparam logic [OP_W-1:0] c_OP_RD    = OP_W'(4'h9);
  localparam logic [OP_W-1:0] c_OP_ACK   = OP_W'(4'hA);
  localparam logic [OP_W-1:0] c_OP_CLR   = OP_W'(4'hE);
  localparam logic [OP_W-1:0] c_OP_ABORT = OP_W'(4'hF);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_W_FILL    = 4'd1,
    S_W_WAIT_SW = 4'd2,
    S_W_SWITCH  = 4'd3,
    S_W_LAUNCH  = 4'd4,
    S_R_LAUNCH  = 4'd5,
    S_R_WAIT_SW = 4'd6,
    S_R_SWITCH  = 4'd7,
    S_R_ASK     = 4'd8,
    S_R_STORE   = 4'd9,
    S_R_VALID   = 4'd10
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_SR_W-1:0]    r_sr, w_sr_nxt;
  logic [7:0]           r_st, w_st_nxt;
  logic [31:0]          r_addr, w_addr_nxt;
  logic [c_BE_W-1:0]    r_be, w_be_nxt;
  logic [BURST_W-1:0]   r_burst, w_burst_nxt;
  logic [BURST_W-1:0]   r_rem, w_rem_nxt;
  logic [PP_ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [DATA_W-1:0]    r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0]    r_rdata, w_rdata_nxt;

  logic                 w_shift, w_capture, w_busy, w_consume;
  logic [OP_W-1:0]      w_op, w_tag;
  logic [DATA_W-1:0]    w_payload;
  logic [31:0]          w_addr_pl;

  assign w_shift   = JCE & JSHIFT;
  assign w_capture = JCE & ~JSHIFT;
  assign w_op      = r_sr[OP_W-1:0];
  assign w_payload = r_sr[c_SR_W-1:OP_W];
  assign w_busy    = |r_st[4:3];
  // Bit 1 of a data frame tells the host another word follows this one.
  assign w_tag     = {{(OP_W-2){1'b0}}, (r_rem != '0), 1'b1};
  assign w_consume = (r_state == S_R_VALID) && r_st[5] &&
                     (w_capture || (JUPDATE && (w_op == c_OP_ACK)));

  if (DATA_W >= 32) begin : g_addr_wide
    assign w_addr_pl = w_payload[31:0];
  end else begin : g_addr_narrow
    assign w_addr_pl = {{(32-DATA_W){1'b0}}, w_payload};
  end

  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_st    <= '0;
      r_addr  <= '0;
      r_be    <= '0;
      r_burst <= '0;
      r_rem   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_st    <= w_st_nxt;
      r_addr  <= w_addr_nxt;
      r_be    <= w_be_nxt;
      r_burst <= w_burst_nxt;
      r_rem   <= w_rem_nxt;
      r_idx   <= w_idx_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_st_nxt    = r_st;
    w_addr_nxt  = r_addr;
    w_be_nxt    = r_be;
    w_burst_nxt = r_burst;
    w_rem_nxt   = r_rem;
    w_idx_nxt   = r_idx;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;

    if (w_shift) begin
      w_sr_nxt = {JTDI, r_sr[c_SR_W-1:1]};
    end else if (w_capture) begin
      if (r_st[5]) w_sr_nxt = {r_rdata, w_tag};
      else         w_sr_nxt = {{(DATA_W-8){1'b0}}, r_st, {OP_W{1'b0}}};
    end

    case (r_state)
      S_W_FILL: begin
        // idx stops at the last word so it never runs past the burst.
        if (r_rem == '0) begin
          w_state_nxt = S_W_WAIT_SW;
        end else begin
          w_rem_nxt   = r_rem - BURST_W'(1);
          w_idx_nxt   = r_idx + PP_ADDR_W'(1);
          w_state_nxt = S_IDLE;
        end
      end
      S_W_WAIT_SW: if (bus.switch_ready) w_state_nxt = S_W_SWITCH;
      S_W_SWITCH:  w_state_nxt = S_W_LAUNCH;
      S_W_LAUNCH: begin
        w_idx_nxt   = '0;
        w_rem_nxt   = r_burst;
        w_st_nxt[3] = 1'b0;
        w_state_nxt = S_IDLE;
      end
      S_R_LAUNCH:  w_state_nxt = S_R_WAIT_SW;
      S_R_WAIT_SW: if (bus.switch_ready) w_state_nxt = S_R_SWITCH;
      S_R_SWITCH:  w_state_nxt = S_R_ASK;
      S_R_ASK:     w_state_nxt = S_R_STORE;
      S_R_STORE: begin
        w_rdata_nxt = bus.pp_dout;
        w_st_nxt[5] = 1'b1;
        w_state_nxt = S_R_VALID;
      end
      S_R_VALID: begin
        if (w_consume) begin
          w_st_nxt[5] = 1'b0;
          if (r_rem == '0) begin
            w_st_nxt[4] = 1'b0;
            w_idx_nxt   = '0;
            w_rem_nxt   = r_burst;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt   = r_idx + PP_ADDR_W'(1);
            w_rem_nxt   = r_rem - BURST_W'(1);
            w_state_nxt = S_R_ASK;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Update decode comes after the FSM so ABORT overrides its effects.
    if (JUPDATE) begin
      case (w_op)
        c_OP_ADDR, c_OP_BE, c_OP_SIZE: begin
          if (w_busy) begin
            w_st_nxt[6] = 1'b1;
          end else if (w_op == c_OP_ADDR) begin
            w_addr_nxt  = w_addr_pl;
            w_st_nxt[0] = 1'b1;
          end else if (w_op == c_OP_BE) begin
            w_be_nxt    = w_payload[c_BE_W-1:0];
            w_st_nxt[1] = 1'b1;
          end else begin
            w_burst_nxt = w_payload[BURST_W-1:0];
            w_rem_nxt   = w_payload[BURST_W-1:0];
            w_st_nxt[2] = 1'b1;
          end
        end
        c_OP_WDATA: begin
          if (r_st[4] || (r_state != S_IDLE)) begin
            w_st_nxt[6] = 1'b1;
          end else begin
            w_wdata_nxt = w_payload;
            w_st_nxt[3] = 1'b1;
            w_state_nxt = S_W_FILL;
          end
        end
        c_OP_RD: begin
          if (w_busy || (r_state != S_IDLE)) begin
            w_st_nxt[6] = 1'b1;
          end else begin
            w_st_nxt[4] = 1'b1;
            w_state_nxt = S_R_LAUNCH;
          end
        end
        c_OP_CLR: w_st_nxt[7:6] = 2'b00;
        c_OP_ABORT: begin
          w_state_nxt   = S_IDLE;
          w_st_nxt[5:3] = 3'b000;
          w_idx_nxt     = '0;
          w_rem_nxt     = r_burst;
        end
        default: ;
      endcase
    end

    if (bus.dma_error) w_st_nxt[7] = 1'b1;
  end

  always_comb begin
    bus.pp_address      = '0;
    bus.pp_we           = 1'b0;
    bus.pp_din          = '0;
    bus.pp_switch       = 1'b0;
    bus.dma_address     = '0;
    bus.dma_byte_enable = '0;
    bus.dma_burst_size  = '0;
    bus.dma_write_start = 1'b0;
    bus.dma_read_start  = 1'b0;
    case (r_state)
      S_W_FILL: begin
        bus.pp_we      = 1'b1;
        bus.pp_address = r_idx;
        bus.pp_din     = r_wdata;
      end
      S_W_SWITCH, S_R_SWITCH: bus.pp_switch = 1'b1;
      S_W_LAUNCH, S_R_LAUNCH: begin
        bus.dma_write_start = (r_state == S_W_LAUNCH);
        bus.dma_read_start  = (r_state == S_R_LAUNCH);
        bus.dma_address     = r_addr;
        bus.dma_byte_enable = r_be;
        bus.dma_burst_size  = r_burst;
      end
      S_R_ASK: bus.pp_address = r_idx;
      default: ;
    endcase
  end

  assign JTDO       = r_sr[0];
  assign status_out = r_st;
endmodule
`default_nettype wire
